// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: state encoding,
// default timeout and the pipeline word width.
package mem_access_pkg;

  localparam int WORD_W      = 16;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_timeout_ctr.sv
// Request watchdog: counts busy cycles and flags the last
// cycle a request may wait before the FSM aborts it.
module mem_timeout_ctr
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // clear wins over enable so a fresh request starts at zero
  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (enable)
      count_d = count_q + 1'b1;
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign expired = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access.sv
// Memory stage: issues loads/stores over a request/done handshake.
// Build option ALIGN_CHECK_EN rejects odd-address memory ops.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int ADDR_W  = WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [ADDR_W-1:0] alu_in,
  input  logic [ADDR_W-1:0] store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              halt_in,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic              stall,
  output logic              valid_out,
  output logic [ADDR_W-1:0] wb_data,
  output logic              err,
  output logic              halted
);

  state_t            state_q, state_d;
  logic              acc_q, acc_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] wb_q, wb_d;
  logic              err_q, err_d;
  logic              halted_q, halted_d;

  logic mem_op;
  logic misalign;
  logic accept;
  logic issue;
  logic busy;
  logic expired;

  assign mem_op = mem_read | mem_write;

`ifdef ALIGN_CHECK_EN
  assign misalign = alu_in[0];
`else
  assign misalign = 1'b0;
`endif

  // acc_q blocks the instruction upstream keeps holding
  // for one cycle after its request completes
  assign busy   = (state_q == BUSY);
  assign accept = !busy & valid_in & !halted_q & !acc_q;
  assign issue  = accept & mem_op & !misalign;
  assign stall  = busy | issue;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (issue),
    .enable (busy),
    .expired(expired)
  );

  // next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mem_en_d    = mem_en_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    wb_d        = wb_q;
    halted_d    = halted_q;
    if (!stall)
      acc_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (issue) begin
            state_d     = BUSY;
            acc_d       = 1'b1;
            mem_en_d    = 1'b1;
            mem_wr_d    = !mem_read;
            mem_addr_d  = alu_in;
            mem_wdata_d = store_data;
          end else if (mem_op) begin
            valid_d = 1'b1;
            err_d   = 1'b1;
            wb_d    = '0;
          end else begin
            valid_d = 1'b1;
            wb_d    = alu_in;
            if (halt_in)
              halted_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (mem_done) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          valid_d  = 1'b1;
          wb_d     = mem_wr_q ? mem_addr_q : mem_rdata;
        end else if (expired) begin
          state_d  = IDLE;
          mem_en_d = 1'b0;
          valid_d  = 1'b1;
          err_d    = 1'b1;
          wb_d     = '0;
        end
      end
      default: ;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      acc_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= 1'b0;
      wb_q        <= '0;
      err_q       <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      valid_q     <= valid_d;
      wb_q        <= wb_d;
      err_q       <= err_d;
      halted_q    <= halted_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign valid_out = valid_q;
  assign wb_data   = wb_q;
  assign err       = err_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed + randomized bench for mem_access with a
// transaction-level reference model.
module tb_mem_access;

  localparam int TO = 16;

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_BOTH} kind_e;

  typedef struct {
    bit          issues;
    bit          wr;
    bit          err;
    logic [15:0] wb;
    int          mem_cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] alu_in;
  logic [15:0] store_data;
  logic        mem_read;
  logic        mem_write;
  logic        halt_in;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        stall;
  logic        valid_out;
  logic [15:0] wb_data;
  logic        err;
  logic        halted;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access #(
    .TIMEOUT(TO),
    .ADDR_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .alu_in    (alu_in),
    .store_data(store_data),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .halt_in   (halt_in),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .stall     (stall),
    .valid_out (valid_out),
    .wb_data   (wb_data),
    .err       (err),
    .halted    (halted)
  );

  task automatic chk1(input string tag, input logic obs,
                      input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Transaction model: what one instruction should produce.
  // dly = cycles after mem_en rises until mem_done (>=TO: never).
  function automatic exp_t model(kind_e k, logic [15:0] a,
                                 logic [15:0] rd, int dly);
    exp_t e;
    e.issues     = 1'b0;
    e.wr         = 1'b0;
    e.err        = 1'b0;
    e.wb         = a;
    e.mem_cycles = 0;
    if (k == K_ALU) return e;
`ifdef ALIGN_CHECK_EN
    if (a[0]) begin
      e.err = 1'b1;
      e.wb  = 16'h0000;
      return e;
    end
`endif
    e.issues = 1'b1;
    e.wr     = (k == K_STORE);
    if (dly < TO) begin
      e.mem_cycles = dly + 1;
      e.wb         = e.wr ? a : rd;
    end else begin
      e.mem_cycles = TO;
      e.err        = 1'b1;
      e.wb         = 16'h0000;
    end
    return e;
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(kind_e k, logic [15:0] a, logic [15:0] sd,
                     logic [15:0] rd, int dly);
    exp_t e;
    e = model(k, a, rd, dly);
    valid_in   = 1'b1;
    alu_in     = a;
    store_data = sd;
    mem_read   = (k == K_LOAD) || (k == K_BOTH);
    mem_write  = (k == K_STORE) || (k == K_BOTH);
    halt_in    = 1'b0;
    #1;
    chk1("stall_accept", stall, e.issues);
    @(posedge clk);
    #1;
    if (!e.issues) valid_in = 1'b0;
    @(negedge clk);
    for (int c = 0; c < e.mem_cycles; c++) begin
      chk1("mem_en_busy", mem_en, 1'b1);
      chk1("stall_busy", stall, 1'b1);
      chk16("mem_addr", mem_addr, a);
      chk1("mem_wr", mem_wr, e.wr);
      if (e.wr) chk16("mem_wdata", mem_wdata, sd);
      chk1("valid_busy", valid_out, 1'b0);
      if (c == dly) begin
        mem_done  = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = 16'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      mem_done = 1'b0;
    end
    chk1("valid_out", valid_out, 1'b1);
    chk1("err", err, e.err);
    chk16("wb_data", wb_data, e.wb);
    chk1("mem_en_after", mem_en, 1'b0);
    chk1("stall_after", stall, 1'b0);
    @(posedge clk);
    #1;
    valid_in  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    chk1("valid_pulse", valid_out, 1'b0);
    chk1("err_pulse", err, 1'b0);
    chk1("no_reaccept", mem_en, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int dly;
    kind_e k;
    rst        = 1'b0;
    valid_in   = 1'b0;
    alu_in     = '0;
    store_data = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    halt_in    = 1'b0;
    mem_rdata  = '0;
    mem_done   = 1'b0;
    #12;
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_wr", mem_wr, 1'b0);
    chk16("rst_mem_addr", mem_addr, 16'h0000);
    chk16("rst_mem_wdata", mem_wdata, 16'h0000);
    chk1("rst_valid", valid_out, 1'b0);
    chk16("rst_wb", wb_data, 16'h0000);
    chk1("rst_err", err, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();

    // mem_done in IDLE must be ignored
    mem_done  = 1'b1;
    mem_rdata = 16'hDEAD;
    idle_cycle();
    mem_done = 1'b0;
    chk1("idle_done_en", mem_en, 1'b0);
    chk1("idle_done_valid", valid_out, 1'b0);

    run(K_LOAD, 16'h0040, 16'h0000, 16'hBEEF, 3);
    run(K_STORE, 16'h0010, 16'h1234, 16'h7777, 1);
    run(K_ALU, 16'h00AA, 16'h0000, 16'h0000, 0);
    run(K_LOAD, 16'h0020, 16'h0000, 16'h1111, 99);
    run(K_LOAD, 16'h0022, 16'h0000, 16'h2222, TO - 1);
    run(K_BOTH, 16'h0030, 16'h9999, 16'h3333, 0);
    run(K_LOAD, 16'h0003, 16'h0000, 16'h5555, 2);

    // async reset in the middle of a request
    valid_in = 1'b1;
    alu_in   = 16'h0050;
    mem_read = 1'b1;
    idle_cycle();
    idle_cycle();
    chk1("mid_mem_en", mem_en, 1'b1);
    rst      = 1'b0;
    valid_in = 1'b0;
    mem_read = 1'b0;
    #1;
    chk1("arst_mem_en", mem_en, 1'b0);
    chk1("arst_valid", valid_out, 1'b0);
    chk1("arst_stall", stall, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idle_cycle();
    chk1("arst_post_en", mem_en, 1'b0);
    chk1("arst_post_valid", valid_out, 1'b0);

    // randomized instructions
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 3);
      k = kind_e'(r);
      r = $urandom_range(0, 9);
      if (r < 7) dly = r;
      else if (r == 7) dly = TO - 1;
      else dly = 99;
      run(k, 16'($urandom), 16'($urandom), 16'($urandom), dly);
    end

    // HALT, then a load that must be ignored
    valid_in = 1'b1;
    halt_in  = 1'b1;
    alu_in   = 16'h0BAD;
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    halt_in  = 1'b0;
    @(negedge clk);
    chk1("halt_valid", valid_out, 1'b1);
    chk16("halt_wb", wb_data, 16'h0BAD);
    chk1("halt_halted", halted, 1'b1);
    valid_in = 1'b1;
    alu_in   = 16'h0060;
    mem_read = 1'b1;
    #1;
    chk1("halt_stall", stall, 1'b0);
    for (int c = 0; c < 3; c++) begin
      idle_cycle();
      chk1("halt_mem_en", mem_en, 1'b0);
      chk1("halt_no_valid", valid_out, 1'b0);
      chk1("halt_sticky", halted, 1'b1);
    end
    rst      = 1'b0;
    valid_in = 1'b0;
    mem_read = 1'b0;
    #1;
    chk1("halt_rst", halted, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    run(K_ALU, 16'h4321, 16'h0000, 16'h0000, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the 16-bit pipeline. Consumes the execute-stage results: the ALU result is used as the address or pass-through value, and the forwarded register data is used as store data.
- Drives a multi-cycle data memory through a request/done handshake.
- Stalls upstream while an access is outstanding.
- Presents one registered result per instruction to writeback.

Parameters:
- TIMEOUT, 16: maximum cycles a request may wait for mem_done before it is aborted with err.
- ADDR_W, 16: address/data width; fixed at 16 for this ISA.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- valid_in  in  1  an instruction from execute is present this cycle.
- alu_in  in  16  ALU result: memory address for loads/stores, writeback value otherwise.
- store_data  in  16  store data (second register operand).
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- halt_in  in  1  instruction is HALT.
- mem_rdata  in  16  read data from data memory; valid when mem_done=1.
- mem_done  in  1  memory completes the current request this cycle.
- mem_en  out  1  request active; held high until mem_done.
- mem_wr  out  1  1 = write request, 0 = read request; qualified by mem_en.
- mem_addr  out  16  request address, held stable for the whole request.
- mem_wdata  out  16  write data, held stable for the whole request.
- stall  out  1  upstream must hold its outputs; combinational.
- valid_out  out  1  wb_data is valid for exactly one cycle.
- wb_data  out  16  load data, or alu_in for non-memory instructions.
- err  out  1  one-cycle pulse together with valid_out on timeout or misalignment.
- halted  out  1  sticky once HALT is accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, timer=0. All outputs are 0: mem_en, mem_wr, mem_addr, mem_wdata, valid_out, wb_data, err, halted.
- mem_read and mem_write both set: treated as a load.
- States:
  - IDLE
    - Accepts only if valid_in=1 and halted=0.
    - Memory op: latch address, wdata and op into mem_* registers; mem_en=1 from the next cycle; go to BUSY; timer=0.
    - No memory op: next cycle valid_out=1, wb_data=alu_in, err=0.
    - halt_in=1: halted=1 next cycle, plus a one-cycle valid_out with wb_data=alu_in. From then on every valid_in is ignored and stall=0.
  - BUSY
    - mem_en=1 and all mem_* outputs held; timer increments each cycle.
    - On mem_done=1: mem_en=0 next cycle; valid_out=1 next cycle; wb_data=mem_rdata for a read, alu_in latched for a write; return to IDLE.
    - If timer == TIMEOUT-1 and mem_done=0: abort. mem_en=0; valid_out=1 with err=1 and wb_data=0; go to IDLE.
    - mem_done on the same cycle as timeout: mem_done wins, no err.
- stall = (state==BUSY) or (state==IDLE and valid_in and (mem_read or mem_write) and !halted).
  - The accept cycle itself stalls, so upstream holds the same instruction for one cycle. It must not be re-accepted: a one-bit accepted flag suppresses the next IDLE accept for that held instruction, cleared when stall drops.
- Latency:
  - Non-memory instruction: 1 cycle.
  - Memory instruction: 2 + (cycles until mem_done).
- valid_out and err are single-cycle pulses.
- mem_done while in IDLE: ignored.
- Async reset mid-request drops the request immediately: mem_en=0, no valid_out.

Optional Feature:
- ALIGN_CHECK_EN
  - Defined: a memory op with alu_in[0]=1 is not issued. Next cycle valid_out=1, err=1, wb_data=0; the state stays IDLE and stall is 0 for that instruction.
  - Undefined: odd addresses are issued unchanged; memory ignores bit 0 as it chooses, and err is raised only on timeout.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, BUSY=1'b1), TIMEOUT default, and the 16-bit word-width constant used across the pipeline.
- One sub-module: mem_timeout_ctr.
  - Inputs: clk, rst, clear, enable.
  - Output: expired when count == TIMEOUT-1.
  - Keeps the FSM free of counter arithmetic.

Test Plan:
- Load, alu_in=16'h0040, mem_done asserted 3 cycles after mem_en rises with mem_rdata=16'hBEEF -> mem_addr=16'h0040, mem_wr=0, stall high throughout, then valid_out pulse with wb_data=16'hBEEF, err=0.
- Store, alu_in=16'h0010, store_data=16'h1234, mem_done after 1 cycle -> mem_wr=1, mem_wdata=16'h1234, then valid_out with wb_data=16'h0010.
- Non-memory instruction, alu_in=16'h00AA -> stall=0, valid_out next cycle with wb_data=16'h00AA; no mem_en.
- Load with mem_done never asserted, TIMEOUT=16 -> mem_en high for 16 cycles, then valid_out+err pulse, wb_data=0, back in IDLE.
- HALT then load -> halted=1 sticky, subsequent load ignored (mem_en stays 0, stall=0); rst low -> halted=0.
- ALIGN_CHECK_EN defined, load at alu_in=16'h0003 -> no mem_en, next cycle valid_out+err.
